// File: rtl/neo_sound_mailbox.sv
// 68k <-> Z80 sound mailbox: command/reply latches, pending flags and Z80 NMI request.
// Optional command-overrun counter is built when SOUND_MAILBOX_OVERRUN_EN is defined.
module neo_sound_mailbox #(
    parameter logic [7:0] CMD_RESET   = 8'h00,
    parameter int         NMI_MIN_LOW = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_EN_68K_P,
    input  logic       nSOUNDWR,
    input  logic       nSOUNDRD,
    input  logic [7:0] M68K_DATA_IN,
    input  logic       nSDZ80R,
    input  logic       nSDZ80W,
    input  logic       nSDZ80CLR,
    input  logic       nNMI_EN,
    input  logic       nNMI_DIS,
    input  logic [7:0] SDD_IN,
    output logic [7:0] SDD_OUT,
    output logic [7:0] M68K_DATA_OUT,
    output logic       CMD_PENDING,
    output logic       REPLY_PENDING,
    output logic       nZ80NMI_REQ,
    output logic [3:0] CMD_OVERRUN
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } nmi_state_t;

    localparam logic [3:0] CNT_LOAD = 4'(NMI_MIN_LOW - 1);

    logic       wr_prev_r, rd_prev_r, zr_prev_r, zw_prev_r, zc_prev_r, ne_prev_r, nd_prev_r;
    logic       wr_ev_s, rd_ev_s, zr_ev_s, zw_ev_s, zc_ev_s, ne_ev_s, nd_ev_s;
    logic       cmd_pending_nx_s, nmi_en_nx_s, nmi_en_r;
    nmi_state_t state_r, state_nx_s;
    logic [3:0] cnt_r, cnt_nx_s;

    // 68k strobes only count as samples on enabled cycles, so their history advances only then.
    assign wr_ev_s = CLK_EN_68K_P & wr_prev_r & ~nSOUNDWR;
    assign rd_ev_s = CLK_EN_68K_P & rd_prev_r & ~nSOUNDRD;
    assign zr_ev_s = zr_prev_r & ~nSDZ80R;
    assign zw_ev_s = zw_prev_r & ~nSDZ80W;
    assign zc_ev_s = zc_prev_r & ~nSDZ80CLR;
    assign ne_ev_s = ne_prev_r & ~nNMI_EN;
    assign nd_ev_s = nd_prev_r & ~nNMI_DIS;

    // Strobe history registers for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_prev_r <= 1'b1;
            rd_prev_r <= 1'b1;
            zr_prev_r <= 1'b1;
            zw_prev_r <= 1'b1;
            zc_prev_r <= 1'b1;
            ne_prev_r <= 1'b1;
            nd_prev_r <= 1'b1;
        end else begin
            if (CLK_EN_68K_P) begin
                wr_prev_r <= nSOUNDWR;
                rd_prev_r <= nSOUNDRD;
            end
            zr_prev_r <= nSDZ80R;
            zw_prev_r <= nSDZ80W;
            zc_prev_r <= nSDZ80CLR;
            ne_prev_r <= nNMI_EN;
            nd_prev_r <= nNMI_DIS;
        end
    end

    // Next pending flag and NMI enable; writes beat reads/clears, disable beats enable.
    always_comb begin
        cmd_pending_nx_s = CMD_PENDING;
        nmi_en_nx_s      = nmi_en_r;
        if (wr_ev_s) begin
            cmd_pending_nx_s = 1'b1;
        end else if (zr_ev_s || zc_ev_s) begin
            cmd_pending_nx_s = 1'b0;
        end else begin
            cmd_pending_nx_s = CMD_PENDING;
        end
        if (nd_ev_s) begin
            nmi_en_nx_s = 1'b0;
        end else if (ne_ev_s) begin
            nmi_en_nx_s = 1'b1;
        end else begin
            nmi_en_nx_s = nmi_en_r;
        end
    end

    // NMI next state; the minimum-low counter is loaded only when leaving IDLE.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        if (nd_ev_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wr_ev_s && nmi_en_r) begin
                        state_nx_s = ST_ASSERT;
                        cnt_nx_s   = CNT_LOAD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_r == 4'd0) begin
                        state_nx_s = cmd_pending_nx_s ? ST_HOLD : ST_IDLE;
                    end else begin
                        cnt_nx_s = cnt_r - 4'd1;
                    end
                end
                ST_HOLD: begin
                    state_nx_s = cmd_pending_nx_s ? ST_HOLD : ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Mailbox latches, flags and NMI state registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SDD_OUT       <= CMD_RESET;
            M68K_DATA_OUT <= 8'h00;
            CMD_PENDING   <= 1'b0;
            REPLY_PENDING <= 1'b0;
            nmi_en_r      <= 1'b0;
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            nZ80NMI_REQ   <= 1'b1;
        end else begin
            if (wr_ev_s) begin
                SDD_OUT <= M68K_DATA_IN;
            end else if (zc_ev_s) begin
                SDD_OUT <= CMD_RESET;
            end
            if (zw_ev_s) begin
                M68K_DATA_OUT <= SDD_IN;
                REPLY_PENDING <= 1'b1;
            end else if (rd_ev_s) begin
                REPLY_PENDING <= 1'b0;
            end
            CMD_PENDING <= cmd_pending_nx_s;
            nmi_en_r    <= nmi_en_nx_s;
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            nZ80NMI_REQ <= (state_nx_s == ST_IDLE);
        end
    end

`ifdef SOUND_MAILBOX_OVERRUN_EN
    logic [3:0] overrun_r;

    // Saturating count of commands overwritten before the Z80 read them.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overrun_r <= 4'd0;
        end else if (zc_ev_s) begin
            overrun_r <= 4'd0;
        end else if (wr_ev_s && CMD_PENDING && (overrun_r != 4'd15)) begin
            overrun_r <= overrun_r + 4'd1;
        end
    end

    assign CMD_OVERRUN = overrun_r;
`else
    assign CMD_OVERRUN = 4'd0;
`endif

endmodule

// File: tb/tb_neo_sound_mailbox.sv
// Table-driven bench for neo_sound_mailbox; expected outputs are queued when a vector is driven
// and compared on the following falling edge.
module tb_neo_sound_mailbox;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
`ifdef SOUND_MAILBOX_OVERRUN_EN
    localparam bit OV_ON = 1'b1;
`else
    localparam bit OV_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, wr, rd, zr, zw, zc, ne, nd;
    logic [7:0] md, sd;
    logic [7:0] sdd_out, m68k_out;
    logic       cmd_p, rep_p, nmi;
    logic [3:0] ovr;

    typedef struct {
        logic       rst, en, wr, rd;
        logic [7:0] md;
        logic       zr, zw, zc, ne, nd;
        logic [7:0] sd;
        logic [7:0] so, mo;
        logic       cp, rp, nmi;
        logic [3:0] ov;
    } vec_t;

    typedef struct {
        int          idx;
        logic [22:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    neo_sound_mailbox dut (
        .CLK(clk), .RESET(rst), .CLK_EN_68K_P(en),
        .nSOUNDWR(wr), .nSOUNDRD(rd), .M68K_DATA_IN(md),
        .nSDZ80R(zr), .nSDZ80W(zw), .nSDZ80CLR(zc),
        .nNMI_EN(ne), .nNMI_DIS(nd), .SDD_IN(sd),
        .SDD_OUT(sdd_out), .M68K_DATA_OUT(m68k_out),
        .CMD_PENDING(cmd_p), .REPLY_PENDING(rep_p),
        .nZ80NMI_REQ(nmi), .CMD_OVERRUN(ovr)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic e, input logic w, input logic d,
                                input logic [7:0] mdv, input logic z_r, input logic z_w,
                                input logic z_c, input logic n_e, input logic n_d,
                                input logic [7:0] sdv, input logic [7:0] so, input logic [7:0] mo,
                                input logic cp, input logic rp, input logic nm, input logic [3:0] ov);
        vec_t v;
        v.rst = r; v.en = e; v.wr = w; v.rd = d; v.md = mdv;
        v.zr = z_r; v.zw = z_w; v.zc = z_c; v.ne = n_e; v.nd = n_d; v.sd = sdv;
        v.so = so; v.mo = mo; v.cp = cp; v.rp = rp; v.nmi = nm; v.ov = ov;
        tbl.push_back(v);
    endfunction

    // Idle inputs; expected outputs given.
    function automatic void idle(input logic [7:0] so, input logic [7:0] mo,
                                 input logic cp, input logic rp, input logic nm, input logic [3:0] ov);
        add(L, H, H, H, 8'h00, H, H, H, H, H, 8'h00, so, mo, cp, rp, nm, ov);
    endfunction

    task automatic check_one();
        sb_t         s;
        logic [22:0] act;
        s   = sbq.pop_front();
        act = {sdd_out, m68k_out, cmd_p, rep_p, nmi, ovr};
        n_checks++;
        if (act !== s.exp) begin
            n_fail++;
            $display("FAIL step%0d: got SDD_OUT=%h M68K_OUT=%h CMD_P=%b REP_P=%b NMI=%b OVR=%0d, required SDD_OUT=%h M68K_OUT=%h CMD_P=%b REP_P=%b NMI=%b OVR=%0d",
                     s.idx, act[22:15], act[14:7], act[6], act[5], act[4], act[3:0],
                     s.exp[22:15], s.exp[14:7], s.exp[6], s.exp[5], s.exp[4], s.exp[3:0]);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; wr = 1'b1; rd = 1'b1; md = 8'h00;
        zr = 1'b1; zw = 1'b1; zc = 1'b1; ne = 1'b1; nd = 1'b1; sd = 8'h00;

        // reset and NMI enable
        add(H, H, H, H, 8'h00, H, H, H, H, H, 8'h00, 8'h00, 8'h00, L, L, H, 4'd0);
        add(H, H, H, H, 8'h00, H, H, H, H, H, 8'h00, 8'h00, 8'h00, L, L, H, 4'd0);
        idle(8'h00, 8'h00, L, L, H, 4'd0);
        add(L, H, H, H, 8'h00, H, H, H, L, H, 8'h00, 8'h00, 8'h00, L, L, H, 4'd0);
        idle(8'h00, 8'h00, L, L, H, 4'd0);
        // write 0x3C, Z80 read one cycle later: NMI low exactly 4 samples
        add(L, H, L, H, 8'h3C, H, H, H, H, H, 8'h00, 8'h3C, 8'h00, H, L, L, 4'd0);
        idle(8'h3C, 8'h00, H, L, L, 4'd0);
        add(L, H, H, H, 8'h00, L, H, H, H, H, 8'h00, 8'h3C, 8'h00, L, L, L, 4'd0);
        idle(8'h3C, 8'h00, L, L, L, 4'd0);
        idle(8'h3C, 8'h00, L, L, H, 4'd0);
        // Z80 reply write with simultaneous 68k read, then a lone read
        add(L, H, H, L, 8'h00, H, L, H, H, H, 8'hA5, 8'h3C, 8'hA5, L, H, H, 4'd0);
        idle(8'h3C, 8'hA5, L, H, H, 4'd0);
        add(L, H, H, L, 8'h00, H, H, H, H, H, 8'h00, 8'h3C, 8'hA5, L, L, H, 4'd0);
        idle(8'h3C, 8'hA5, L, L, H, 4'd0);
        // write strobe held low 20 cycles, enable every second cycle, data changes mid-hold
        for (int k = 0; k < 20; k++) begin
            if (k == 0)
                add(L, L, L, H, 8'h77, H, H, H, H, H, 8'h00, 8'h3C, 8'hA5, L, L, H, 4'd0);
            else
                add(L, (k % 2 == 1) ? H : L, L, H, (k < 10) ? 8'h77 : 8'h88, H, H, H, H, H, 8'h00,
                    8'h77, 8'hA5, H, L, L, 4'd0);
        end
        idle(8'h77, 8'hA5, H, L, L, 4'd0);
        // write coinciding with Z80 clear; write wins
        add(L, H, L, H, 8'h5A, H, H, L, H, H, 8'h00, 8'h5A, 8'hA5, H, L, L, 4'd0);
        idle(8'h5A, 8'hA5, H, L, L, 4'd0);
        // enable + disable together in HOLD: disable wins
        add(L, H, H, H, 8'h00, H, H, H, L, L, 8'h00, 8'h5A, 8'hA5, H, L, H, 4'd0);
        idle(8'h5A, 8'hA5, H, L, H, 4'd0);
        add(L, H, H, H, 8'h00, L, H, H, H, H, 8'h00, 8'h5A, 8'hA5, L, L, H, 4'd0);
        idle(8'h5A, 8'hA5, L, L, H, 4'd0);
        // write while disabled, later enable: no retroactive NMI
        add(L, H, L, H, 8'h01, H, H, H, H, H, 8'h00, 8'h01, 8'hA5, H, L, H, 4'd0);
        idle(8'h01, 8'hA5, H, L, H, 4'd0);
        add(L, H, H, H, 8'h00, H, H, H, L, H, 8'h00, 8'h01, 8'hA5, H, L, H, 4'd0);
        idle(8'h01, 8'hA5, H, L, H, 4'd0);
        add(L, H, H, H, 8'h00, H, H, L, H, H, 8'h00, 8'h00, 8'hA5, L, L, H, 4'd0);
        idle(8'h00, 8'hA5, L, L, H, 4'd0);
        // second write during ASSERT must not reload the minimum-low counter
        add(L, H, L, H, 8'h11, H, H, H, H, H, 8'h00, 8'h11, 8'hA5, H, L, L, 4'd0);
        idle(8'h11, 8'hA5, H, L, L, 4'd0);
        add(L, H, L, H, 8'h22, H, H, H, H, H, 8'h00, 8'h22, 8'hA5, H, L, L, 4'd1);
        idle(8'h22, 8'hA5, H, L, L, 4'd1);
        add(L, H, H, H, 8'h00, L, H, H, H, H, 8'h00, 8'h22, 8'hA5, L, L, H, 4'd1);
        idle(8'h22, 8'hA5, L, L, H, 4'd1);
        // 18 writes without a Z80 read: overrun saturates
        for (int i = 0; i < 18; i++) begin
            add(L, H, L, H, 8'(i + 1), H, H, H, H, H, 8'h00, 8'(i + 1), 8'hA5, H, L, L,
                (i + 1 > 15) ? 4'd15 : 4'(i + 1));
            idle(8'(i + 1), 8'hA5, H, L, L, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
        end
        add(L, H, H, H, 8'h00, H, H, L, H, H, 8'h00, 8'h00, 8'hA5, L, L, H, 4'd0);
        idle(8'h00, 8'hA5, L, L, H, 4'd0);
        // RESET during ASSERT aborts the NMI hold at once
        add(L, H, L, H, 8'h99, H, H, H, H, H, 8'h00, 8'h99, 8'hA5, H, L, L, 4'd0);
        idle(8'h99, 8'hA5, H, L, L, 4'd0);
        add(H, H, H, H, 8'h00, H, H, H, H, H, 8'h00, 8'h00, 8'h00, L, L, H, 4'd0);
        idle(8'h00, 8'h00, L, L, H, 4'd0);

        foreach (tbl[i]) begin
            sb_t s;
            @(negedge clk);
            if (sbq.size() > 0) check_one();
            rst = tbl[i].rst; en = tbl[i].en; wr = tbl[i].wr; rd = tbl[i].rd; md = tbl[i].md;
            zr = tbl[i].zr; zw = tbl[i].zw; zc = tbl[i].zc; ne = tbl[i].ne; nd = tbl[i].nd;
            sd = tbl[i].sd;
            s.idx = i;
            s.exp = {tbl[i].so, tbl[i].mo, tbl[i].cp, tbl[i].rp, tbl[i].nmi,
                     OV_ON ? tbl[i].ov : 4'd0};
            sbq.push_back(s);
        end
        @(negedge clk);
        if (sbq.size() > 0) check_one();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neo_sound_mailbox.md
Name: neo_sound_mailbox

Overview:
- Synchronous 68k↔Z80 sound-communication mailbox beside the Z80 controller; consumes its nSDZ80R/nSDZ80W/nSDZ80CLR decodes.
- Holds the 68k→Z80 command byte and the Z80→68k reply byte, with pending flags.
- Produces the NMI request that the Z80 controller gates into nZ80NMI.
- All strobes are sampled on CLK; no strobe is used as a clock.

Parameters:
- CMD_RESET, 8'h00, command latch value after reset and after nSDZ80CLR.
- NMI_MIN_LOW, 4, minimum CLK cycles nZ80NMI_REQ stays low once asserted (1..15).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- CLK_EN_68K_P  in  1  68k-side sample enable; 68k strobes are sampled only on cycles where this is high.
- nSOUNDWR  in  1  68k command-write strobe, active low.
- nSOUNDRD  in  1  68k reply-read strobe, active low.
- M68K_DATA_IN  in  8  68k data bus, low byte.
- nSDZ80R  in  1  Z80 command-read strobe, active low.
- nSDZ80W  in  1  Z80 reply-write strobe, active low.
- nSDZ80CLR  in  1  Z80 command-clear strobe, active low.
- nNMI_EN  in  1  Z80 NMI-enable strobe, active low.
- nNMI_DIS  in  1  Z80 NMI-disable strobe, active low.
- SDD_IN  in  8  Z80 data bus.
- SDD_OUT  out  8  command byte presented to Z80.
- M68K_DATA_OUT  out  8  reply byte presented to 68k.
- CMD_PENDING  out  1  command written, not yet read by Z80.
- REPLY_PENDING  out  1  reply written, not yet read by 68k.
- nZ80NMI_REQ  out  1  active-low NMI request to Z80 controller.
- CMD_OVERRUN  out  4  overwrite counter (optional feature).

Behaviour:
- Reset:
  - SDD_OUT=CMD_RESET, M68K_DATA_OUT=0.
  - CMD_PENDING=0, REPLY_PENDING=0, NMI enable=0.
  - nZ80NMI_REQ=1, hold counter=0, CMD_OVERRUN=0.
  - Previous-strobe registers=1.
  - RESET mid-operation aborts any NMI hold immediately.
- Edge detection: each strobe is registered.
  - An event is a previous=1, current=0 sample.
  - Z80 strobes are sampled every CLK; 68k strobes only when CLK_EN_68K_P=1.
  - A held-low strobe produces exactly one event.
- Latency: latches and flags update on the same CLK edge the event is detected; outputs are registered and visible the cycle after.
- 68k write event: SDD_OUT←M68K_DATA_IN, CMD_PENDING←1, NMI state machine triggered.
- Z80 read event: CMD_PENDING←0; SDD_OUT is unchanged.
- Z80 clear event: SDD_OUT←CMD_RESET, CMD_PENDING←0.
- Z80 write event: M68K_DATA_OUT←SDD_IN, REPLY_PENDING←1.
- 68k read event: REPLY_PENDING←0.
- Simultaneous events:
  - 68k write + Z80 read/clear: write wins; new data latched, CMD_PENDING=1.
  - Z80 write + 68k read: write wins; REPLY_PENDING=1.
  - nNMI_EN + nNMI_DIS together: disable wins.
- NMI state machine:
  - IDLE: nZ80NMI_REQ=1. On 68k write event with NMI enabled → ASSERT, counter loaded with NMI_MIN_LOW-1.
  - ASSERT: nZ80NMI_REQ=0; counter decrements to 0, then → HOLD.
  - HOLD: nZ80NMI_REQ=0 while CMD_PENDING=1; → IDLE once CMD_PENDING=0.
  - A Z80 read during ASSERT does not shorten the minimum low time.
  - A new 68k write during ASSERT or HOLD keeps NMI low and does not reload the counter.
  - Disable event in any state → IDLE next cycle.
  - Write while disabled: no NMI; a later enable with CMD_PENDING=1 does not raise NMI retroactively.

Optional Feature:
- Macro: SOUND_MAILBOX_OVERRUN_EN.
- Defined: CMD_OVERRUN is a saturating 4-bit count of 68k write events occurring while CMD_PENDING=1.
  - Saturates at 15, never wraps.
  - Cleared by Z80 clear event or RESET; unaffected by Z80 read.
- Not defined: CMD_OVERRUN tied to 4'd0 and the counter is not built.

Test Plan:
- RESET high 2 cycles, then low → SDD_OUT=CMD_RESET, M68K_DATA_OUT=0x00, both pending=0, nZ80NMI_REQ=1.
- nNMI_EN pulse, then 68k write 0x3C with CLK_EN_68K_P=1 → next cycle SDD_OUT=0x3C, CMD_PENDING=1, nZ80NMI_REQ=0. Z80 read 1 cycle later → nZ80NMI_REQ stays low exactly NMI_MIN_LOW (4) cycles total, then 1; CMD_PENDING=0.
- Z80 write 0xA5 with nSOUNDRD falling on the same sample → M68K_DATA_OUT=0xA5, REPLY_PENDING=1. A later lone 68k read → REPLY_PENDING=0.
- nSOUNDWR held low 20 cycles with CLK_EN_68K_P every 2nd cycle → exactly one write event. 68k write with nSDZ80CLR coinciding → SDD_OUT=new data, CMD_PENDING=1.
- NMI disabled, 68k write 0x01 → nZ80NMI_REQ stays 1. Then nNMI_EN → still 1. nNMI_EN and nNMI_DIS together during HOLD → IDLE, nZ80NMI_REQ=1.
- Macro defined, 18 68k writes with no Z80 read → CMD_OVERRUN=15 (saturated). Z80 clear → 0. Macro undefined → always 0.
